// File: rtl/mult4_hex_display.sv
// Time-multiplexed product display: latches two 3-bit factors once per
// digit phase, multiplies them, and shows the 8-bit product as two hex
// digits on one 7-segment display, alternating high/low nibble.
module mult4_hex_display #(
  parameter int MAX_COUNT = 1250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_factor_a,
  input  logic [2:0] i_factor_b,
  output logic [6:0] o_segments,
  output logic       o_lsb_digit
);

  localparam logic [11:0] CNT_TERM = 12'(MAX_COUNT);

  logic [11:0] r_cnt;
  logic [3:0]  r_fa_in;
  logic [3:0]  r_fb_in;
  logic [3:0]  r_fa;
  logic [3:0]  r_fb;
  logic [3:0]  r_digit;
  logic        r_lsb_sel;
  logic        r_lsb_led;

  logic        w_term;
  logic [7:0]  w_product;

  // Hex digit to active-high segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign w_term    = (r_cnt == CNT_TERM);
  // Full-width product of the zero-extended operands; never truncated.
  assign w_product = {4'b0000, r_fa} * {4'b0000, r_fb};

  // Dwell counter, operand latching, phase toggle and displayed digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_fa_in   <= '0;
      r_fb_in   <= '0;
      r_fa      <= '0;
      r_fb      <= '0;
      r_digit   <= '0;
      r_lsb_sel <= 1'b0;
      r_lsb_led <= 1'b0;
    end else if (w_term) begin
      // Terminal cycle: commit the last sampled factors and flip the phase;
      // the visible digit follows on the next cycle.
      r_cnt     <= '0;
      r_fa      <= r_fa_in;
      r_fb      <= r_fb_in;
      r_lsb_sel <= ~r_lsb_sel;
    end else begin
      r_cnt     <= r_cnt + 12'd1;
      r_fa_in   <= {1'b0, i_factor_a};
      r_fb_in   <= {1'b0, i_factor_b};
      r_lsb_led <= r_lsb_sel;
      r_digit   <= r_lsb_sel ? w_product[3:0] : w_product[7:4];
    end
  end

  assign o_segments  = hex_to_seg(r_digit);
  assign o_lsb_digit = r_lsb_led;

endmodule

// File: tb/tb_mult4_hex_display.sv
// Directed bench for mult4_hex_display with a short dwell (MAX_COUNT=4).
module tb_mult4_hex_display;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] i_factor_a = '0;
  logic [2:0] i_factor_b = '0;
  logic [6:0] o_segments;
  logic       o_lsb_digit;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16];

  mult4_hex_display #(.MAX_COUNT(MC)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_factor_a (i_factor_a),
    .i_factor_b (i_factor_b),
    .o_segments (o_segments),
    .o_lsb_digit(o_lsb_digit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp_seg, input logic exp_lsb);
    checks++;
    assert (o_segments === exp_seg) else begin
      errors++;
      $error("FAIL %s segs observed=%h expected=%h", tag, o_segments, exp_seg);
    end
    checks++;
    assert (o_lsb_digit === exp_lsb) else begin
      errors++;
      $error("FAIL %s lsb observed=%b expected=%b", tag, o_lsb_digit, exp_lsb);
    end
  endtask

  task automatic chk_seg(input string tag, input logic [6:0] exp_seg);
    checks++;
    assert (o_segments === exp_seg) else begin
      errors++;
      $error("FAIL %s segs observed=%h expected=%h", tag, o_segments, exp_seg);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // From reset: 5 cycles of "0"/high, then 5 of low nibble, then 5 of high nibble.
  task automatic check_pair(input int a, input int b);
    int p;
    logic [3:0] lo;
    logic [3:0] hi;
    p  = a * b;
    lo = 4'(p % 16);
    hi = 4'(p / 16);
    i_factor_a = 3'(a);
    i_factor_b = 3'(b);
    do_reset();
    repeat (MC + 1) tick();
    chk($sformatf("pre a=%0d b=%0d", a, b), 7'h3F, 1'b0);
    for (int i = 0; i <= MC; i++) begin
      tick();
      chk($sformatf("lo a=%0d b=%0d c=%0d", a, b, i), seg_tab[lo], 1'b1);
    end
    for (int i = 0; i <= MC; i++) begin
      tick();
      chk($sformatf("hi a=%0d b=%0d c=%0d", a, b, i), seg_tab[hi], 1'b0);
    end
  endtask

  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

    // Reset state, then zero factors keep showing "0".
    i_factor_a = 3'd0;
    i_factor_b = 3'd0;
    do_reset();
    chk("reset", 7'h3F, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_seg($sformatf("zero c=%0d", i), 7'h3F);
    end

    // 3*5 = 0x0F, 7*7 = 0x31 with exact phase lengths.
    check_pair(3, 5);
    check_pair(7, 7);

    // Mid-phase factor changes: only the last pre-terminal sample counts.
    i_factor_a = 3'd2;
    i_factor_b = 3'd4;
    do_reset();
    repeat (6) tick();
    chk("mid lo 0x08", 7'h7F, 1'b1);
    i_factor_a = 3'd6;
    tick();
    tick();
    chk("mid lo hold", 7'h7F, 1'b1);
    i_factor_a = 3'd2;
    repeat (3) tick();
    chk("mid hi 0x08", 7'h3F, 1'b0);
    i_factor_a = 3'd6;
    repeat (3) tick();
    chk("mid hi hold", 7'h3F, 1'b0);
    tick();
    tick();
    chk("mid lo 0x18", 7'h7F, 1'b1);
    repeat (5) tick();
    chk("mid hi 0x18", 7'h06, 1'b0);

    // Full sweep of every factor pair.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        check_pair(a, b);
      end
    end

    // Reset during a low-nibble phase aborts and restarts the counter.
    i_factor_a = 3'd3;
    i_factor_b = 3'd5;
    do_reset();
    repeat (7) tick();
    chk("pre-abort lo", 7'h71, 1'b1);
    reset = 1'b1;
    tick();
    chk("abort", 7'h3F, 1'b0);
    reset = 1'b0;
    for (int i = 0; i <= MC; i++) begin
      tick();
      chk($sformatf("restart c=%0d", i), 7'h3F, 1'b0);
    end
    tick();
    chk("restart toggle", 7'h71, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
